n_register_chain: RTL and testbench
===================================

N_REGISTER_CHAIN -- requirements
Module: n_register_chain

Interface
REQ-001 The block SHALL have parameter N, default 1: number of register stages (pipeline depth); legal range 0..1024.
REQ-002 The block SHALL have parameter W, default 16: data width in bits; legal range 1..1024.
REQ-003 The block SHALL have port Clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in, input, W bits: data entering the chain.
REQ-006 The block SHALL have port out, output, W bits: data leaving the chain.

Function
REQ-007 When N=0, out SHALL equal in combinationally: zero latency, no registers, Clock and Reset ignored.
REQ-008 When N>=1, the block SHALL contain exactly N cascaded W-bit registers: stage 1 loads in, stage k loads stage k-1, out is driven by stage N.
REQ-009 When N>=1, a value present on in at rising edge t SHALL appear on out immediately after rising edge t+N-1 (latency N cycles) and SHALL hold for one cycle unless in repeats.
REQ-010 The chain SHALL shift every cycle with no enable and no stall; throughput is one word per cycle.
REQ-011 Data SHALL pass bit-exact: no sign extension, truncation or arithmetic.
REQ-012 out SHALL be a pure register output for N>=1, with no combinational path from in to out.
REQ-013 Elaboration SHALL fail with an error message for a negative N or for W<1.

Reset
REQ-014 When Reset=1 at a rising edge, all N stages SHALL load 0, so out=0 after that edge (N>=1).
REQ-015 Reset SHALL take priority over shifting; the word on in at that edge is discarded.
REQ-016 After Reset deasserts, the first word sampled SHALL reach out after N edges; out SHALL read 0 until then.
REQ-017 If Reset is applied mid-stream, all in-flight words SHALL be lost; there is no partial flush.
REQ-018 Reset SHALL have no effect on out when N=0.

Structure
REQ-019 Shared package n_register_chain_pkg SHALL hold only DEFAULT_N=1 and DEFAULT_W=16; no typedefs are needed.
REQ-020 One sub-module, register_stage, SHALL be used: a W-bit register with synchronous active-high reset.
REQ-021 The top level SHALL instantiate register_stage N times through a generate loop.
REQ-022 The top level SHALL use a generate branch for N=0 that provides a direct wire.
REQ-023 Each stage output SHALL be exposed internally as a named array element for debug probing.

Verification
REQ-024 N=0, W=16: set in=16'h4A55, then 16'h515F -> out equals in in the same delta cycle, with no clock edge needed.
REQ-025 N=3, W=16: after reset, drive 16'h4A55, 16'h515F, 16'h0001 on three consecutive edges -> out=16'h4A55 after the third edge, 16'h515F after the fourth, 16'h0001 after the fifth.
REQ-026 N=3: drive 16'hCCCC for one cycle, then 16'h0000 -> out shows 16'hCCCC for exactly one cycle, 3 cycles later, then 0.
REQ-027 N=3: assert Reset for one edge while three nonzero words are in flight -> out=0 after that edge; the flushed words never appear.
REQ-028 N=1, W=1 and N=8, W=32 with a random stream -> out equals in delayed by N cycles for 1000 cycles.
REQ-029 N=0: assert Reset while in=16'h00FF -> out remains 16'h00FF.

Source files
------------

// File: rtl/n_register_chain_pkg.sv
// Shared defaults for the register chain.
//   DEFAULT_N : default pipeline depth (register stages)
//   DEFAULT_W : default data width in bits
package n_register_chain_pkg;

  localparam int DEFAULT_N = 1;
  localparam int DEFAULT_W = 16;

endpackage

// File: rtl/n_register_chain_register_stage.sv
// One W-bit pipeline register with synchronous active-high reset.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, loads zero
//   d_i   : data in
//   q_o   : registered data out
module register_stage
  import n_register_chain_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = d_i;
    if (rst_i) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/n_register_chain.sv
// N-deep chain of W-bit registers; out is in delayed by N cycles.
// N=0 degenerates to a plain wire with Clock and Reset unused.
//   Clock : clock, rising edge
//   Reset : synchronous active-high reset, clears every stage
//   in    : data entering the chain
//   out   : data leaving the chain (register output when N>=1)
module n_register_chain
  import n_register_chain_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  if (N < 0) begin : g_bad_n
    $error("n_register_chain: N must be >= 0 (got %0d)", N);
  end
  if (W < 1) begin : g_bad_w
    $error("n_register_chain: W must be >= 1 (got %0d)", W);
  end

  if (N == 0) begin : g_wire
    assign out = in;
    logic unused_clk_rst;
    assign unused_clk_rst = Clock ^ Reset;
  end else if (N >= 1) begin : g_chain
    // stage_q[0] is the chain input; stage_q[k] is the output of stage k.
    logic [W-1:0] stage_q [0:N];

    assign stage_q[0] = in;

    for (genvar k = 1; k <= N; k++) begin : g_stage
      register_stage #(
        .W(W)
      ) u_stage (
        .clk_i(Clock),
        .rst_i(Reset),
        .d_i  (stage_q[k-1]),
        .q_o  (stage_q[k])
      );
    end

    assign out = stage_q[N];
  end

endmodule

// File: tb/tb_n_register_chain.sv
// Bench for n_register_chain: four instances (N=0/W=16, N=3/W=16,
// N=1/W=1, N=8/W=32) sharing one clock.
module tb_n_register_chain;

  logic clk;

  logic        rst0, rst3, rst1, rst8;
  logic [15:0] in0, in3, out0, out3;
  logic [0:0]  in1, out1;
  logic [31:0] in8, out8;

  n_register_chain #(.N(0), .W(16)) u_n0 (.Clock(clk), .Reset(rst0), .in(in0), .out(out0));
  n_register_chain #(.N(3), .W(16)) u_n3 (.Clock(clk), .Reset(rst3), .in(in3), .out(out3));
  n_register_chain #(.N(1), .W(1))  u_n1 (.Clock(clk), .Reset(rst1), .in(in1), .out(out1));
  n_register_chain #(.N(8), .W(32)) u_n8 (.Clock(clk), .Reset(rst8), .in(in8), .out(out8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One row per clock edge: inputs held across the edge, expected out after it.
  typedef struct {
    logic        rst;
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [23];

  logic [31:0] h1 [$];
  logic [31:0] h8 [$];

  initial begin
    logic [31:0] e1, e8;

    n_vec = 0;
    n_bad = 0;
    rst0 = 1'b0; in0 = '0;
    rst3 = 1'b1; in3 = '0;
    rst1 = 1'b1; in1 = '0;
    rst8 = 1'b1; in8 = '0;

    tbl[0]  = '{1'b1, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 16'hABCD, 16'h0000};
    tbl[2]  = '{1'b0, 16'h4A55, 16'h0000};
    tbl[3]  = '{1'b0, 16'h515F, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0001, 16'h4A55};
    tbl[5]  = '{1'b0, 16'h0000, 16'h515F};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0001};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b0, 16'hCCCC, 16'h0000};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 16'h0000, 16'hCCCC};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000};
    tbl[12] = '{1'b0, 16'h1111, 16'h0000};
    tbl[13] = '{1'b0, 16'h2222, 16'h0000};
    tbl[14] = '{1'b0, 16'h3333, 16'h1111};
    tbl[15] = '{1'b1, 16'h4444, 16'h0000};
    tbl[16] = '{1'b0, 16'h0000, 16'h0000};
    tbl[17] = '{1'b0, 16'h0000, 16'h0000};
    tbl[18] = '{1'b0, 16'h0000, 16'h0000};
    tbl[19] = '{1'b0, 16'h5555, 16'h0000};
    tbl[20] = '{1'b0, 16'h0000, 16'h0000};
    tbl[21] = '{1'b0, 16'h0000, 16'h5555};
    tbl[22] = '{1'b0, 16'h0000, 16'h0000};

    // N=0: combinational pass-through, no clock edge involved.
    in0 = 16'h4A55;
    #1 check("n0_pass_4A55", {16'h0, out0}, 32'h4A55);
    in0 = 16'h515F;
    #1 check("n0_pass_515F", {16'h0, out0}, 32'h515F);

    // N=0: reset is ignored.
    rst0 = 1'b1;
    in0  = 16'h00FF;
    #1 check("n0_rst_comb", {16'h0, out0}, 32'h00FF);
    @(posedge clk);
    #1 check("n0_rst_edge", {16'h0, out0}, 32'h00FF);
    @(posedge clk);
    #1 check("n0_rst_edge2", {16'h0, out0}, 32'h00FF);
    rst0 = 1'b0;

    // N=3 table: reset, latency, single pulse, mid-stream flush, post-reset fill.
    for (int i = 0; i < 23; i++) begin
      rst3 = tbl[i].rst;
      in3  = tbl[i].din;
      @(posedge clk);
      #1 check($sformatf("n3_row%0d", i), {16'h0, out3}, {16'h0, tbl[i].exp});
    end
    rst3 = 1'b0;
    in3  = '0;

    // Random streams for N=1/W=1 and N=8/W=32 against a delay-line model:
    // the model keeps the last N accepted words since the most recent reset.
    h1.delete();
    h8.delete();
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      #1;
      if (rst1) h1.delete();
      else      h1.push_back({31'h0, in1});
      if (h1.size() > 1) void'(h1.pop_front());
      if (rst8) h8.delete();
      else      h8.push_back(in8);
      if (h8.size() > 8) void'(h8.pop_front());
      e1 = (h1.size() == 1) ? h1[0] : 32'h0;
      e8 = (h8.size() == 8) ? h8[0] : 32'h0;
      check("n1_rand", {31'h0, out1}, e1);
      check("n8_rand", out8, e8);

      rst1 = (c < 2) || ($urandom_range(0, 99) == 0);
      rst8 = (c < 2) || ($urandom_range(0, 149) == 0);
      in1  = 1'($urandom);
      in8  = $urandom;
      in0  = 16'($urandom);
      #1;
      if (c % 50 == 0) check("n0_rand", {16'h0, out0}, {16'h0, in0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
